// File: rtl/alu_seq.sv
// ----------------------------------------------------------------------------
// alu_seq
//
// Accumulator sequencer that wraps an external 8-bit combinational ALU. It
// takes one command at a time over a valid/ready handshake and drives the ALU
// operands and opcode from registers. It captures the ALU result into the
// accumulator and returns the result over a second valid/ready handshake.
// With an always-ready consumer it completes one command every three cycles.
//
// Ports
//   clk, reset              system clock, synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake (ready only in IDLE)
//   cmd_op[3:0]             0=LOAD, 1..B=ALU op, C=READ, D..F=illegal
//   cmd_data[7:0]           ALU in_b operand, or the LOAD value
//   alu_a/alu_b/alu_op      registered drive to the ALU
//   alu_res/alu_z/alu_c     ALU result and flags
//   res_valid/res_ready     result handshake
//   res_data/res_zero/res_carry/res_err   registered result fields
//   acc[7:0]                current accumulator
//   op_count[7:0]           completed result handshakes, wrapping
// ----------------------------------------------------------------------------
module alu_seq #(
   parameter logic [7:0] ACC_RESET = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_op,
   input  logic [7:0] cmd_data,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [3:0] alu_op,
   input  logic [7:0] alu_res,
   input  logic       alu_z,
   input  logic       alu_c,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [7:0] res_data,
   output logic       res_zero,
   output logic       res_carry,
   output logic       res_err,
   output logic [7:0] acc,
   output logic [7:0] op_count
);

   localparam logic [3:0] OP_LOAD     = 4'h0;
   localparam logic [3:0] OP_ALU_LAST = 4'hB;
   localparam logic [3:0] OP_READ     = 4'hC;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state;
   state_t state_next;
   logic   cmd_fire;
   logic   res_fire;

   // State register; reset drops any in-flight command without a response.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake decode. EXEC always lasts exactly one cycle so
   // the ALU sees stable registered inputs for a full clock period.
   always_comb begin
      state_next = state;
      cmd_ready  = 1'b0;
      res_valid  = 1'b0;
      cmd_fire   = 1'b0;
      res_fire   = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               cmd_fire   = 1'b1;
               state_next = EXEC;
            end
         end
         EXEC: begin
            state_next = RESP;
         end
         RESP: begin
            res_valid = 1'b1;
            if (res_ready) begin
               res_fire   = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath. Operands are latched on command acceptance; the result fields
   // are written only at the end of EXEC, so they stay stable through RESP no
   // matter how long the consumer stalls. LOAD uses the latched operand in
   // alu_b rather than cmd_data, which may already have changed.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc       <= ACC_RESET;
         op_count  <= 8'h00;
         alu_a     <= ACC_RESET;
         alu_b     <= 8'h00;
         alu_op    <= 4'h0;
         res_data  <= 8'h00;
         res_zero  <= 1'b0;
         res_carry <= 1'b0;
         res_err   <= 1'b0;
      end else begin
         if (cmd_fire) begin
            alu_a  <= acc;
            alu_b  <= cmd_data;
            alu_op <= cmd_op;
         end
         if (state == EXEC) begin
            res_carry <= 1'b0;
            res_err   <= 1'b0;
            if (alu_op == OP_LOAD) begin
               acc      <= alu_b;
               res_data <= alu_b;
               res_zero <= (alu_b == 8'h00);
            end else if (alu_op <= OP_ALU_LAST) begin
               acc       <= alu_res;
               res_data  <= alu_res;
               res_zero  <= alu_z;
               res_carry <= alu_c;
            end else if (alu_op == OP_READ) begin
               res_data <= acc;
               res_zero <= (acc == 8'h00);
            end else begin
               res_data <= acc;
               res_zero <= 1'b0;
               res_err  <= 1'b1;
            end
         end
         if (res_fire) begin
            op_count <= op_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// ----------------------------------------------------------------------------
// tb_alu_seq
//
// Self-checking bench for alu_seq. Provides a behavioural 8-bit ALU on the
// DUT's ALU port, drives directed and random commands, and compares every
// response against an arithmetic reference model of the accumulator.
// ----------------------------------------------------------------------------
module tb_alu_seq;

   logic       clk;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_op;
   logic [7:0] cmd_data;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [3:0] alu_op;
   logic [7:0] alu_res;
   logic       alu_z;
   logic       alu_c;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_data;
   logic       res_zero;
   logic       res_carry;
   logic       res_err;
   logic [7:0] acc;
   logic [7:0] op_count;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   logic [7:0] exp_acc;
   logic [7:0] exp_count;

   alu_seq #(.ACC_RESET(8'h00)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_res   (alu_res),
      .alu_z     (alu_z),
      .alu_c     (alu_c),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_zero  (res_zero),
      .res_carry (res_carry),
      .res_err   (res_err),
      .acc       (acc),
      .op_count  (op_count)
   );

   // Free-running clock and a posedge counter used to measure throughput.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cycle <= cycle + 1;

   // Behavioural ALU: 1 ADD, 2 SUB, 3 INC, 4 DEC, 5 AND, 6 OR, 7 XOR, 8 NOT a,
   // 9 SHL, A SHR, B pass b. Carry on SUB/DEC means "no borrow".
   function automatic logic [9:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
      int         r;
      logic       c;
      logic [7:0] y;
      c = 1'b0;
      r = 0;
      case (op)
         4'h1: begin r = int'(a) + int'(b); c = (r > 255); end
         4'h2: begin r = int'(a) - int'(b); c = (a >= b); end
         4'h3: begin r = int'(a) + 1; c = (r > 255); end
         4'h4: begin r = int'(a) - 1; c = (a != 8'h00); end
         4'h5: r = int'(a & b);
         4'h6: r = int'(a | b);
         4'h7: r = int'(a ^ b);
         4'h8: r = int'(~a);
         4'h9: begin r = int'(a) * 2; c = a[7]; end
         4'hA: begin r = int'(a) / 2; c = a[0]; end
         4'hB: r = int'(b);
         default: r = 0;
      endcase
      y = 8'(r);
      return {c, (y == 8'h00), y};
   endfunction

   always_comb begin
      {alu_c, alu_z, alu_res} = alu_fn(alu_op, alu_a, alu_b);
   end

   // Reference model of one command: result fields and the new accumulator.
   task automatic model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] d,
                        output logic [7:0] res, output logic z, output logic c,
                        output logic err, output logic [7:0] new_acc);
      err     = 1'b0;
      c       = 1'b0;
      new_acc = a;
      if (op == 4'h0) begin
         res     = d;
         z       = (d == 8'h00);
         new_acc = d;
      end else if (op <= 4'hB) begin
         {c, z, res} = alu_fn(op, a, d);
         new_acc     = res;
      end else if (op == 4'hC) begin
         res = a;
         z   = (a == 8'h00);
      end else begin
         res = a;
         z   = 1'b0;
         err = 1'b1;
      end
   endtask

   // Single comparison point: counts the check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   // Runs one full command from an IDLE negedge to the next IDLE negedge.
   // The result is held for 'hold' extra cycles before res_ready is raised.
   task automatic applyStimulus(input logic [3:0] op, input logic [7:0] data,
                                input int hold, output int acc_cycle);
      logic [7:0] e_res;
      logic       e_z;
      logic       e_c;
      logic       e_err;
      logic [7:0] e_acc;
      model(op, exp_acc, data, e_res, e_z, e_c, e_err, e_acc);
      checkOutput("idle_cmd_ready", 32'(cmd_ready), 32'd1);
      cmd_op    = op;
      cmd_data  = data;
      cmd_valid = 1'b1;
      res_ready = 1'b0;
      @(negedge clk);
      acc_cycle = cycle;
      cmd_valid = 1'b0;
      cmd_op    = 4'($urandom);
      cmd_data  = 8'($urandom);
      checkOutput("exec_res_valid", 32'(res_valid), 32'd0);
      checkOutput("exec_cmd_ready", 32'(cmd_ready), 32'd0);
      checkOutput("exec_alu_a", 32'(alu_a), 32'(exp_acc));
      checkOutput("exec_alu_b", 32'(alu_b), 32'(data));
      checkOutput("exec_alu_op", 32'(alu_op), 32'(op));
      @(negedge clk);
      for (int k = 0; k <= hold; k++) begin
         checkOutput("resp_valid", 32'(res_valid), 32'd1);
         checkOutput("resp_cmd_ready", 32'(cmd_ready), 32'd0);
         checkOutput("resp_data", 32'(res_data), 32'(e_res));
         checkOutput("resp_zero", 32'(res_zero), 32'(e_z));
         checkOutput("resp_carry", 32'(res_carry), 32'(e_c));
         checkOutput("resp_err", 32'(res_err), 32'(e_err));
         checkOutput("resp_acc", 32'(acc), 32'(e_acc));
         if (k == hold) res_ready = 1'b1;
         else @(negedge clk);
      end
      @(negedge clk);
      res_ready = 1'b0;
      exp_acc   = e_acc;
      exp_count = exp_count + 8'd1;
      checkOutput("done_res_valid", 32'(res_valid), 32'd0);
      checkOutput("done_cmd_ready", 32'(cmd_ready), 32'd1);
      checkOutput("done_op_count", 32'(op_count), 32'(exp_count));
      checkOutput("done_acc", 32'(acc), 32'(exp_acc));
   endtask

   // Checks every register that reset is defined to clear.
   task automatic checkReset();
      checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
      checkOutput("rst_acc", 32'(acc), 32'h00);
      checkOutput("rst_op_count", 32'(op_count), 32'h00);
      checkOutput("rst_alu_a", 32'(alu_a), 32'h00);
      checkOutput("rst_alu_b", 32'(alu_b), 32'h00);
      checkOutput("rst_alu_op", 32'(alu_op), 32'h0);
      checkOutput("rst_res_data", 32'(res_data), 32'h00);
      checkOutput("rst_res_flags", 32'({res_zero, res_carry, res_err}), 32'd0);
   endtask

   initial begin
      int cyc;
      int prev_cyc;
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 4'h0;
      cmd_data  = 8'h00;
      res_ready = 1'b0;
      exp_acc   = 8'h00;
      exp_count = 8'h00;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkReset();

      // LOAD F0 then ADD 20 wraps with carry out.
      $display("[TB] load/add");
      applyStimulus(4'h0, 8'hF0, 0, cyc);
      applyStimulus(4'h1, 8'h20, 0, cyc);
      checkOutput("add_res", 32'(res_data), 32'h10);
      checkOutput("add_carry", 32'(res_carry), 32'd1);
      checkOutput("add_zero", 32'(res_zero), 32'd0);
      checkOutput("add_op_count", 32'(op_count), 32'd2);

      // INC from FF wraps to zero; DEC from zero gives FF with no carry.
      $display("[TB] inc/dec");
      applyStimulus(4'h0, 8'hFF, 1, cyc);
      applyStimulus(4'h3, 8'h00, 0, cyc);
      checkOutput("inc_res", 32'(res_data), 32'h00);
      checkOutput("inc_flags", 32'({res_zero, res_carry}), 32'b11);
      applyStimulus(4'h4, 8'h00, 0, cyc);
      checkOutput("dec_res", 32'(res_data), 32'hFF);
      checkOutput("dec_carry", 32'(res_carry), 32'd0);

      // SUB held for 5 cycles with a READ waiting behind it.
      $display("[TB] stall with pending command");
      applyStimulus(4'h0, 8'h09, 0, cyc);
      cmd_op    = 4'h2;
      cmd_data  = 8'h05;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_op   = 4'hC;
      cmd_data = 8'hA5;
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         checkOutput("stall_valid", 32'(res_valid), 32'd1);
         checkOutput("stall_data", 32'(res_data), 32'h04);
         checkOutput("stall_cmd_ready", 32'(cmd_ready), 32'd0);
         checkOutput("stall_alu_b", 32'(alu_b), 32'h05);
         @(negedge clk);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      exp_acc   = 8'h04;
      exp_count = exp_count + 8'd1;
      checkOutput("stall_done_ready", 32'(cmd_ready), 32'd1);
      checkOutput("stall_done_count", 32'(op_count), 32'(exp_count));
      @(negedge clk);
      cmd_valid = 1'b0;
      checkOutput("pend_cmd_ready", 32'(cmd_ready), 32'd0);
      checkOutput("pend_alu_b", 32'(alu_b), 32'hA5);
      checkOutput("pend_alu_op", 32'(alu_op), 32'hC);
      checkOutput("pend_alu_a", 32'(alu_a), 32'h04);
      @(negedge clk);
      checkOutput("pend_res_data", 32'(res_data), 32'h04);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      exp_count = exp_count + 8'd1;
      checkOutput("pend_op_count", 32'(op_count), 32'(exp_count));

      // Illegal opcode reports an error and leaves acc untouched.
      $display("[TB] illegal opcode");
      applyStimulus(4'h0, 8'h3C, 0, cyc);
      applyStimulus(4'hD, 8'h77, 2, cyc);
      checkOutput("illegal_err", 32'(res_err), 32'd1);
      checkOutput("illegal_data", 32'(res_data), 32'h3C);
      checkOutput("illegal_acc", 32'(acc), 32'h3C);
      applyStimulus(4'hC, 8'h00, 0, cyc);
      checkOutput("after_illegal_err", 32'(res_err), 32'd0);

      // Reset in the middle of an ADD drops it without a response.
      $display("[TB] reset during exec");
      cmd_op    = 4'h1;
      cmd_data  = 8'h11;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      reset     = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkReset();
      @(negedge clk);
      checkOutput("rst_no_valid", 32'(res_valid), 32'd0);
      exp_acc   = 8'h00;
      exp_count = 8'h00;

      // 256 back-to-back READs: op_count wraps and throughput is 3 cycles.
      $display("[TB] 256 reads");
      prev_cyc = 0;
      for (int i = 0; i < 256; i++) begin
         applyStimulus(4'hC, 8'($urandom), 0, cyc);
         if (i > 0) checkOutput("throughput", 32'(cyc - prev_cyc), 32'd3);
         prev_cyc = cyc;
      end
      checkOutput("wrap_op_count", 32'(op_count), 32'h00);

      // Random commands against the reference model.
      $display("[TB] random commands");
      for (int i = 0; i < 100; i++) begin
         applyStimulus(4'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, 3), cyc);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
